// File: rtl/pad_mux_ctrl.sv
// Runtime pad function multiplexer: per-pad select registers with glitch-free
// switching (release pads, hold for a guard interval, then switch) and synchronised pad inputs.
module pad_mux_ctrl #(
    parameter int NPINS        = 14,
    parameter int NFUNC        = 4,
    parameter int SELW         = 2,
    parameter int GUARD_CYCLES = 8,
    parameter int RESET_SEL    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    input  logic [NPINS*SELW-1:0]    cfg_sel,
    output logic                     cfg_ready,
    output logic                     busy,
    output logic [NPINS*SELW-1:0]    cur_sel,
    input  logic [NPINS*NFUNC-1:0]   fn_o,
    input  logic [NPINS*NFUNC-1:0]   fn_oe,
    output logic [NPINS*NFUNC-1:0]   fn_i,
    output logic [NPINS-1:0]         pad_o,
    output logic [NPINS-1:0]         pad_oe,
    input  logic [NPINS-1:0]         pad_i
);

    localparam int CNTW = $clog2(GUARD_CYCLES + 1);
    localparam logic [SELW-1:0] RST_SEL = SELW'(RESET_SEL);

    typedef enum logic [1:0] {
        IDLE,
        QUIESCE,
        GUARD,
        APPLY
    } state_t;

    state_t                  state;
    logic [NPINS*SELW-1:0]   pend_sel;
    logic [NPINS-1:0]        qm;
    logic [NPINS-1:0]        chg;
    logic [NPINS-1:0]        sync_meta;
    logic [NPINS-1:0]        sync_q;
    logic [CNTW-1:0]         cnt;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        chg = '0;
        for (int p = 0; p < NPINS; p++) begin
            chg[p] = (cfg_sel[p*SELW +: SELW] != cur_sel[p*SELW +: SELW]);
        end
    end

    // A request that changes nothing is consumed in IDLE without starting a sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_sel  <= {NPINS{RST_SEL}};
            pend_sel <= '0;
            qm       <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        pend_sel <= cfg_sel;
                        if (|chg) begin
                            qm    <= chg;
                            state <= QUIESCE;
                        end
                    end
                end
                QUIESCE: begin
                    cnt   <= CNTW'(GUARD_CYCLES - 1);
                    state <= GUARD;
                end
                GUARD: begin
                    if (cnt == '0) begin
                        state <= APPLY;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                APPLY: begin
                    cur_sel <= pend_sel;
                    qm      <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= pad_i;
            sync_q    <= sync_meta;
        end
    end

    // Select values beyond the last function park the pad: driven off and inputs masked.
    always_comb begin
        logic [SELW-1:0] s;
        s      = '0;
        pad_o  = '0;
        pad_oe = '0;
        fn_i   = '0;
        for (int p = 0; p < NPINS; p++) begin
            s = cur_sel[p*SELW +: SELW];
            if (int'(s) < NFUNC) begin
                pad_o[p]  = fn_o[p*NFUNC + int'(s)];
                pad_oe[p] = fn_oe[p*NFUNC + int'(s)] & ~qm[p];
                if (!qm[p]) begin
                    fn_i[p*NFUNC + int'(s)] = sync_q[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Self-checking bench for pad_mux_ctrl: directed switch sequences plus random
// function data, checked against a cycle-count model of the select sequencing.
module tb_pad_mux_ctrl;

    localparam int NPINS = 14;
    localparam int NFUNC = 4;
    localparam int SELW  = 2;
    localparam int GUARD = 8;
    localparam int RSEL  = 0;
    localparam int SW    = NPINS * SELW;
    localparam int FW    = NPINS * NFUNC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic [SW-1:0]     cfg_sel;
    logic              cfg_ready;
    logic              busy;
    logic [SW-1:0]     cur_sel;
    logic [FW-1:0]     fn_o;
    logic [FW-1:0]     fn_oe;
    logic [FW-1:0]     fn_i;
    logic [NPINS-1:0]  pad_o;
    logic [NPINS-1:0]  pad_oe;
    logic [NPINS-1:0]  pad_i;

    int n_checks = 0;
    int n_fail   = 0;

    int               exp_sel [NPINS];
    logic [NPINS-1:0] exp_qm;
    logic             exp_busy;
    logic [NPINS-1:0] hist [$];

    pad_mux_ctrl #(
        .NPINS(NPINS), .NFUNC(NFUNC), .SELW(SELW),
        .GUARD_CYCLES(GUARD), .RESET_SEL(RSEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
        .cfg_ready(cfg_ready), .busy(busy), .cur_sel(cur_sel),
        .fn_o(fn_o), .fn_oe(fn_oe), .fn_i(fn_i),
        .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i)
    );

    always #5 clk = ~clk;

    // Pad input history sampled at every running edge; the synchronised value lags by two edges.
    task automatic step();
        @(posedge clk);
        if (rst_n) hist.push_back(pad_i);
        if (hist.size() > 4) void'(hist.pop_front());
        #1;
    endtask

    function automatic logic [SW-1:0] model_sel_vec();
        logic [SW-1:0] v = '0;
        for (int p = 0; p < NPINS; p++) v[p*SELW +: SELW] = SELW'(exp_sel[p]);
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPINS; p++) exp_sel[p] = RSEL;
        exp_qm   = '0;
        exp_busy = 1'b0;
        hist.delete();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [NPINS-1:0] sync, po, poe;
        logic [FW-1:0]    fi;
        int s;
        sync = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
        po = '0; poe = '0; fi = '0;
        for (int p = 0; p < NPINS; p++) begin
            s = exp_sel[p];
            if (s < NFUNC) begin
                po[p]  = fn_o[p*NFUNC + s];
                poe[p] = fn_oe[p*NFUNC + s] && !exp_qm[p];
                if (!exp_qm[p]) fi[p*NFUNC + s] = sync[p];
            end
        end
        checkOutput({tag, ".cur_sel"},   64'(cur_sel),   64'(model_sel_vec()));
        checkOutput({tag, ".busy"},      64'(busy),      64'(exp_busy));
        checkOutput({tag, ".cfg_ready"}, 64'(cfg_ready), 64'(!exp_busy));
        checkOutput({tag, ".pad_o"},     64'(pad_o),     64'(po));
        checkOutput({tag, ".pad_oe"},    64'(pad_oe),    64'(poe));
        checkOutput({tag, ".fn_i"},      64'(fn_i),      64'(fi));
    endtask

    task automatic applyStimulus();
        fn_o  = FW'({$urandom, $urandom});
        fn_oe = FW'({$urandom, $urandom});
        pad_i = NPINS'($urandom);
    endtask

    // Called one step after the accepting edge T; returns just after T+GUARD+3's check.
    task automatic runAfterAccept(input logic [SW-1:0] pend, input bit hold,
                                  input logic [SW-1:0] nxt, input int abort_k);
        logic [NPINS-1:0] chg = '0;
        for (int p = 0; p < NPINS; p++)
            chg[p] = (int'(pend[p*SELW +: SELW]) != exp_sel[p]);
        if (chg == '0) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(); #1; checkAll("nochange"); step();
            end
            return;
        end
        exp_qm   = chg;
        exp_busy = 1'b1;
        for (int k = 1; k <= GUARD + 2; k++) begin
            if (k == abort_k) begin
                rst_n = 1'b0;
                model_reset();
                #1 checkAll("abort");
                @(negedge clk);
                rst_n = 1'b1;
                #1 checkAll("post_abort");
                return;
            end
            if (hold && k == 3) begin
                cfg_valid = 1'b1;
                cfg_sel   = nxt;
            end
            applyStimulus(); #1; checkAll("seq"); step();
        end
        for (int p = 0; p < NPINS; p++) exp_sel[p] = int'(pend[p*SELW +: SELW]);
        exp_qm   = '0;
        exp_busy = 1'b0;
        applyStimulus(); #1; checkAll("done");
    endtask

    task automatic acceptSeq(input logic [SW-1:0] sel, input bit hold,
                             input logic [SW-1:0] nxt, input int abort_k);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        step();
        cfg_valid = 1'b0;
        runAfterAccept(sel, hold, nxt, abort_k);
    endtask

    initial begin
        logic [SW-1:0] v, v2;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_sel = '0;
        fn_o = FW'({$urandom, $urandom}); fn_oe = '1; pad_i = '0;
        model_reset();
        #2 checkAll("reset");
        checkOutput("reset.pad_oe_all", 64'(pad_oe), 64'(14'h3FFF));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 checkAll("reset_release");
        step();

        $display("[TB] single pad switch");
        v = model_sel_vec(); v[9:8] = 2'd1;
        acceptSeq(v, 1'b0, '0, 0);
        checkOutput("single.cur_sel4", 64'(cur_sel[9:8]), 64'd1);

        $display("[TB] no-change request");
        acceptSeq(model_sel_vec(), 1'b0, '0, 0);

        $display("[TB] back-pressure");
        v = model_sel_vec() ^ SW'(1);
        v2 = SW'($urandom);
        v2[3:2] = ~v[3:2];
        acceptSeq(v, 1'b1, v2, 0);
        step();
        cfg_valid = 1'b0;
        runAfterAccept(v2, 1'b0, '0, 0);

        $display("[TB] input routing");
        v = model_sel_vec(); v[13:12] = 2'd2;
        acceptSeq(v, 1'b0, '0, 0);
        pad_i = '0;
        step(); step();
        pad_i[6] = 1'b1;
        step();
        checkOutput("route.fn26_one_cycle", 64'(fn_i[26]), 64'd0);
        checkAll("route1");
        step();
        checkOutput("route.fn_pad6", 64'(fn_i[27:24]), 64'(4'b0100));
        checkAll("route2");

        $display("[TB] reset mid-guard");
        v = model_sel_vec(); v[7:6] = v[7:6] + 2'd1;
        acceptSeq(v, 1'b0, '0, 5);
        step();
        checkAll("after_abort");

        $display("[TB] random sequences");
        for (int i = 0; i < 6; i++) acceptSeq(SW'($urandom), 1'b0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
